// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioner.
// Button indices match the bit order of btn_raw.
package btn_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int N_BTN     = 4;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce counter, press edge
// and optional auto-repeat state machine.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press_tick,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_p;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_q;
    logic             r_press;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcnt_next;
    logic             w_rpt_tick;
    rpt_state_t       r_state;
    rpt_state_t       w_state_next;

    assign w_p = (ACTIVE_LOW != 0) ? ~i_raw : i_raw;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_press    <= 1'b0;
            r_dcnt     <= '0;
        end else begin
            r_sync1    <= w_p;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
            r_press    <= r_stable & ~r_stable_q;
            // Any sample matching the accepted level restarts the count.
            if (r_sync2 == r_stable) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DB_LAST) begin
                r_stable <= r_sync2;
                r_dcnt   <= '0;
            end else begin
                r_dcnt <= r_dcnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_rcnt  <= w_rcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rcnt_next  = r_rcnt + CNT_ONE;
        w_rpt_tick   = 1'b0;
        unique case (r_state)
            RPT_IDLE: begin
                w_rcnt_next = '0;
                if (REPEAT_EN != 0 && r_press) begin
                    w_state_next = RPT_DELAY;
                end
            end
            RPT_DELAY: begin
                if (r_rcnt == RD_LAST) begin
                    w_rpt_tick   = 1'b1;
                    w_state_next = RPT_REPEAT;
                    w_rcnt_next  = '0;
                end
            end
            RPT_REPEAT: begin
                if (r_rcnt == RP_LAST) begin
                    w_rpt_tick  = 1'b1;
                    w_rcnt_next = '0;
                end
            end
            default: begin
                w_state_next = RPT_IDLE;
                w_rcnt_next  = '0;
            end
        endcase
        // Release aborts repeating immediately, without a final tick.
        if (!r_stable) begin
            w_state_next = RPT_IDLE;
            w_rcnt_next  = '0;
            w_rpt_tick   = 1'b0;
        end
    end

    assign o_level      = r_stable_q;
    assign o_press_tick = r_press;
    assign o_tick       = r_press | w_rpt_tick;

endmodule

// File: rtl/btn_conditioner.sv
// Four-button conditioner: per-channel debounce plus opposing-pair
// suppression and a combined press pulse, all registered.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             btn_up_tick,
    output logic             btn_down_tick,
    output logic             btn_left_tick,
    output logic             btn_right_tick,
    output logic             any_tick
);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_tick;
    logic             w_ud;
    logic             w_lr;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_tick;
    logic             r_any;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_raw        (btn_raw[i]),
            .o_level      (w_level[i]),
            .o_press_tick (w_press[i]),
            .o_tick       (w_tick[i])
        );
    end

    assign w_ud = w_tick[BTN_UP] & w_tick[BTN_DOWN];
    assign w_lr = w_tick[BTN_LEFT] & w_tick[BTN_RIGHT];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
            r_tick  <= '0;
            r_any   <= 1'b0;
        end else begin
            r_level           <= w_level;
            r_tick[BTN_UP]    <= w_tick[BTN_UP] & ~w_ud;
            r_tick[BTN_DOWN]  <= w_tick[BTN_DOWN] & ~w_ud;
            r_tick[BTN_LEFT]  <= w_tick[BTN_LEFT] & ~w_lr;
            r_tick[BTN_RIGHT] <= w_tick[BTN_RIGHT] & ~w_lr;
            r_any             <= |w_press;
        end
    end

    assign btn_level      = r_level;
    assign btn_up_tick    = r_tick[BTN_UP];
    assign btn_down_tick  = r_tick[BTN_DOWN];
    assign btn_left_tick  = r_tick[BTN_LEFT];
    assign btn_right_tick = r_tick[BTN_RIGHT];
    assign any_tick       = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: one instance without and one with
// auto-repeat, expected pulses queued at stimulus time.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;

    logic [3:0] lvl0, lvl1;
    logic       up0, dn0, lf0, rt0, any0;
    logic       up1, dn1, lf1, rt1, any1;
    logic [4:0] obs0, obs1;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [4:0] t;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    assign obs0 = {any0, rt0, lf0, dn0, up0};
    assign obs1 = {any1, rt1, lf1, dn1, up1};

    btn_conditioner #(
        .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .CNT_W(8),
        .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut0 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl0), .btn_up_tick(up0), .btn_down_tick(dn0),
        .btn_left_tick(lf0), .btn_right_tick(rt0), .any_tick(any0)
    );

    btn_conditioner #(
        .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .CNT_W(8),
        .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut1 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl1), .btn_up_tick(up1), .btn_down_tick(dn1),
        .btn_left_tick(lf1), .btn_right_tick(rt1), .any_tick(any1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick vectors are {any, right, left, down, up}.
    function automatic logic [4:0] exp0();
        ev_t e;
        exp0 = '0;
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            exp0 = e.t;
        end
    endfunction

    function automatic logic [4:0] exp1();
        ev_t e;
        exp1 = '0;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            exp1 = e.t;
        end
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if ({obs0, lvl0, obs1, lvl1} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d: got %b want 0", cyc,
                         {obs0, lvl0, obs1, lvl1});
            end
            if (i == 2) reset = 1'b0;
        end
    endtask

    task automatic test_clean_press();
        int e, r;
        logic [4:0] ex;
        logic [3:0] lx;
        e = 1 << 30;
        r = 1 << 30;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ex = exp0();
            n_chk++;
            if (obs0 !== ex) begin
                n_fail++;
                $display("FAIL clean_tick cyc=%0d: got %b want %b", cyc, obs0, ex);
            end
            lx = (cyc >= e + 7 && cyc < r + 7) ? 4'b0001 : 4'b0000;
            n_chk++;
            if (lvl0 !== lx) begin
                n_fail++;
                $display("FAIL clean_level cyc=%0d: got %b want %b", cyc, lvl0, lx);
            end
            if (i == 0) begin
                btn_raw[0] = 1'b0;
                e = cyc + 1;
                q0.push_back('{e + 7, 5'b10001});
            end
            if (i == 30) begin
                btn_raw[0] = 1'b1;
                r = cyc + 1;
            end
        end
        n_chk++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL clean_pending: got %0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_bounce();
        int e, r;
        logic [4:0] ex;
        logic [3:0] lx;
        e = 1 << 30;
        r = 1 << 30;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            ex = exp0();
            n_chk++;
            if (obs0 !== ex) begin
                n_fail++;
                $display("FAIL bounce_tick cyc=%0d: got %b want %b", cyc, obs0, ex);
            end
            lx = (cyc >= e + 7 && cyc < r + 7) ? 4'b0010 : 4'b0000;
            n_chk++;
            if (lvl0 !== lx) begin
                n_fail++;
                $display("FAIL bounce_level cyc=%0d: got %b want %b", cyc, lvl0, lx);
            end
            if (i < 20) begin
                btn_raw[1] = ((i / 2) % 2) == 1;
            end else if (i == 20) begin
                btn_raw[1] = 1'b0;
                e = cyc + 1;
                q0.push_back('{e + 7, 5'b10010});
            end else if (i == 45) begin
                btn_raw[1] = 1'b1;
                r = cyc + 1;
            end
        end
        n_chk++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_pending: got %0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_repeat();
        int t, r;
        logic [4:0] ex0, ex1;
        logic [3:0] lx;
        t = 1 << 30;
        r = 1 << 30;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            ex0 = exp0();
            ex1 = exp1();
            n_chk++;
            if (obs0 !== ex0) begin
                n_fail++;
                $display("FAIL norepeat_tick cyc=%0d: got %b want %b", cyc, obs0, ex0);
            end
            n_chk++;
            if (obs1 !== ex1) begin
                n_fail++;
                $display("FAIL repeat_tick cyc=%0d: got %b want %b", cyc, obs1, ex1);
            end
            lx = (cyc >= t && cyc < r + 7) ? 4'b1000 : 4'b0000;
            n_chk++;
            if (lvl1 !== lx) begin
                n_fail++;
                $display("FAIL repeat_level cyc=%0d: got %b want %b", cyc, lvl1, lx);
            end
            if (i == 0) begin
                btn_raw[3] = 1'b0;
                t = cyc + 1 + 7;
                q0.push_back('{t, 5'b11000});
                q1.push_back('{t, 5'b11000});
                q1.push_back('{t + 20, 5'b01000});
                for (int k = 28; k <= 52; k += 8) begin
                    q1.push_back('{t + k, 5'b01000});
                end
            end
            if (cyc + 1 == t + 50) begin
                btn_raw[3] = 1'b1;
                r = cyc + 1;
            end
        end
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_pending: got %0d/%0d want 0/0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic test_opposing();
        int e, r;
        logic [4:0] ex;
        logic [3:0] lx;
        e = 1 << 30;
        r = 1 << 30;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            ex = exp0();
            n_chk++;
            if (obs0 !== ex) begin
                n_fail++;
                $display("FAIL opposing_tick cyc=%0d: got %b want %b", cyc, obs0, ex);
            end
            lx = (cyc >= e + 7 && cyc < r + 7) ? 4'b0011 : 4'b0000;
            n_chk++;
            if (lvl0 !== lx) begin
                n_fail++;
                $display("FAIL opposing_level cyc=%0d: got %b want %b", cyc, lvl0, lx);
            end
            if (i == 0) begin
                btn_raw[1:0] = 2'b00;
                e = cyc + 1;
                q0.push_back('{e + 7, 5'b10000});
            end
            if (i == 30) begin
                btn_raw[1:0] = 2'b11;
                r = cyc + 1;
            end
        end
        n_chk++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL opposing_pending: got %0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_reset_mid();
        int e, a, r;
        logic [4:0] ex;
        logic [3:0] lx;
        e = 1 << 30;
        a = 1 << 30;
        r = 1 << 30;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ex = exp0();
            n_chk++;
            if (obs0 !== ex) begin
                n_fail++;
                $display("FAIL midreset_tick cyc=%0d: got %b want %b", cyc, obs0, ex);
            end
            lx = ((cyc >= e + 7 && cyc < a) || (cyc >= a + 10 && cyc < r + 7))
                 ? 4'b0100 : 4'b0000;
            n_chk++;
            if (lvl0 !== lx) begin
                n_fail++;
                $display("FAIL midreset_level cyc=%0d: got %b want %b", cyc, lvl0, lx);
            end
            if (cyc >= a && cyc < a + 3) begin
                n_chk++;
                if ({obs1, lvl1} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL midreset_rpt cyc=%0d: got %b want 0", cyc, {obs1, lvl1});
                end
            end
            if (i == 0) begin
                btn_raw[2] = 1'b0;
                e = cyc + 1;
                q0.push_back('{e + 7, 5'b10100});
            end
            if (i == 20) begin
                reset = 1'b1;
                a = cyc + 1;
                q0.push_back('{a + 10, 5'b10100});
            end
            if (i == 23) reset = 1'b0;
            if (i == 42) begin
                btn_raw[2] = 1'b1;
                r = cyc + 1;
            end
        end
        n_chk++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_pending: got %0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_chk++;
            if ({obs0, lvl0, obs1, lvl1} !== 18'd0) begin
                n_fail++;
                $display("FAIL glitch cyc=%0d: got %b want 0", cyc,
                         {obs0, lvl0, obs1, lvl1});
            end
            if (i == 2) btn_raw[2] = 1'b0;
            if (i == 5) btn_raw[2] = 1'b1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_opposing();
        test_reset_mid();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
